// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller:
// state encoding and the registered control bundle.
package pipeline_ctrl_pkg;

    localparam logic [1:0] RUN         = 2'd0;
    localparam logic [1:0] LOAD_BUBBLE = 2'd1;
    localparam logic [1:0] FLUSH       = 2'd2;
    localparam logic [1:0] MULDIV_WAIT = 2'd3;

    typedef struct packed {
        logic pc_write_en;
        logic ifid_write_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        pc_write_en:   1'b1,
        ifid_write_en: 1'b1,
        ifid_flush:    1'b0,
        idex_flush:    1'b0,
        exmem_hold:    1'b0
    };

    function automatic ctrl_t ctrl_decode(logic [1:0] st);
        ctrl_t c;
        c = CTRL_RESET;
        unique case (st)
            LOAD_BUBBLE: begin
                c.pc_write_en   = 1'b0;
                c.ifid_write_en = 1'b0;
                c.idex_flush    = 1'b1;
            end
            FLUSH: begin
                c.ifid_flush = 1'b1;
                c.idex_flush = 1'b1;
            end
            MULDIV_WAIT: begin
                c.pc_write_en   = 1'b0;
                c.ifid_write_en = 1'b0;
                c.exmem_hold    = 1'b1;
            end
            default: c = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, shared by the core's performance counters.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard-request arbiter for the 5-stage core: drives pipeline-register
// enables, flushes and holds, plus registered WB-forward selects.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 2,
    parameter int MULDIV_TIMEOUT = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bubble_enable,
    input  logic             fwd_wb_rs1_req,
    input  logic             fwd_wb_rs2_req,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             fwd_wb_rs1_sel,
    output logic             fwd_wb_rs2_sel,
    output logic             muldiv_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int TO_W = (MULDIV_TIMEOUT > 2) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MULDIV_TIMEOUT - 1);
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    logic [1:0]      state, state_n;
    logic [1:0]      flush_cnt, flush_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic            req1, req1_n;
    logic            req2, req2_n;
    logic            timeout_n;
    logic            sel1_n, sel2_n;
    ctrl_t           ctrl, ctrl_n;

    always_comb begin
        state_n   = state;
        flush_n   = flush_cnt;
        to_n      = to_cnt;
        req1_n    = req1;
        req2_n    = req2;
        timeout_n = muldiv_timeout;
        unique case (state)
            RUN: begin
                // A redirect squashes any same-cycle bubble or mul/div
                // request; a start that completes at once never stalls.
                if (branch_taken) begin
                    state_n = FLUSH;
                    flush_n = FLUSH_LAST;
                end else if (muldiv_start && !muldiv_done) begin
                    state_n = MULDIV_WAIT;
                    to_n    = '0;
                end else if (bubble_enable) begin
                    state_n = LOAD_BUBBLE;
                    req1_n  = fwd_wb_rs1_req;
                    req2_n  = fwd_wb_rs2_req;
                end
            end
            LOAD_BUBBLE: begin
                state_n = RUN;
            end
            FLUSH: begin
                if (flush_cnt == 2'd0) begin
                    state_n = RUN;
                end else begin
                    flush_n = flush_cnt - 2'd1;
                end
            end
            MULDIV_WAIT: begin
                to_n = to_cnt + 1'b1;
                if (muldiv_done) begin
                    state_n = RUN;
                end else if (to_cnt == TO_LAST) begin
                    state_n   = RUN;
                    timeout_n = 1'b1;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
        ctrl_n = ctrl_decode(state_n);
        sel1_n = (state == LOAD_BUBBLE) && req1;
        sel2_n = (state == LOAD_BUBBLE) && req2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            flush_cnt      <= 2'd0;
            to_cnt         <= '0;
            req1           <= 1'b0;
            req2           <= 1'b0;
            muldiv_timeout <= 1'b0;
            fwd_wb_rs1_sel <= 1'b0;
            fwd_wb_rs2_sel <= 1'b0;
            ctrl           <= CTRL_RESET;
        end else begin
            state          <= state_n;
            flush_cnt      <= flush_n;
            to_cnt         <= to_n;
            req1           <= req1_n;
            req2           <= req2_n;
            muldiv_timeout <= timeout_n;
            fwd_wb_rs1_sel <= sel1_n;
            fwd_wb_rs2_sel <= sel2_n;
            ctrl           <= ctrl_n;
        end
    end

    assign pc_write_en   = ctrl.pc_write_en;
    assign ifid_write_en = ctrl.ifid_write_en;
    assign ifid_flush    = ctrl.ifid_flush;
    assign idex_flush    = ctrl.idex_flush;
    assign exmem_hold    = ctrl.exmem_hold;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (~pc_write_en),
        .count(stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed and random checks of pipeline_stall_controller against
// a cycle-level behavioural model of the hazard rules.
module tb_pipeline_stall_controller;

    localparam int FC    = 2;
    localparam int TMO   = 8;
    localparam int CW    = 5;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          bubble_enable;
    logic          fwd_wb_rs1_req;
    logic          fwd_wb_rs2_req;
    logic          branch_taken;
    logic          muldiv_start;
    logic          muldiv_done;
    logic          pc_write_en;
    logic          ifid_write_en;
    logic          ifid_flush;
    logic          idex_flush;
    logic          exmem_hold;
    logic          fwd_wb_rs1_sel;
    logic          fwd_wb_rs2_sel;
    logic          muldiv_timeout;
    logic [CW-1:0] stall_count;

    int tests;
    int failed;

    // model: remaining flush cycles, cycles waited on mul/div (-1 = idle)
    int m_flush;
    int m_wait;
    bit m_bubble;
    bit m_l1, m_l2;
    bit m_s1, m_s2;
    bit m_err;
    int m_stalls;

    pipeline_stall_controller #(
        .FLUSH_CYCLES  (FC),
        .MULDIV_TIMEOUT(TMO),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bubble_enable (bubble_enable),
        .fwd_wb_rs1_req(fwd_wb_rs1_req),
        .fwd_wb_rs2_req(fwd_wb_rs2_req),
        .branch_taken  (branch_taken),
        .muldiv_start  (muldiv_start),
        .muldiv_done   (muldiv_done),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_hold    (exmem_hold),
        .fwd_wb_rs1_sel(fwd_wb_rs1_sel),
        .fwd_wb_rs2_sel(fwd_wb_rs2_sel),
        .muldiv_timeout(muldiv_timeout),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush  = 0;
        m_wait   = -1;
        m_bubble = 0;
        m_l1 = 0; m_l2 = 0;
        m_s1 = 0; m_s2 = 0;
        m_err    = 0;
        m_stalls = 0;
    endtask

    task automatic model_step(input bit br, input bit bub, input bit r1,
                              input bit r2, input bit st, input bit dn);
        bit stalled;
        stalled = m_bubble || (m_wait >= 0);
        if (stalled && m_stalls < SMAX) m_stalls++;
        m_s1 = 0;
        m_s2 = 0;
        if (m_bubble) begin
            m_bubble = 0;
            m_s1 = m_l1;
            m_s2 = m_l2;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (m_wait >= 0) begin
            m_wait++;
            if (dn) m_wait = -1;
            else if (m_wait == TMO) begin
                m_wait = -1;
                m_err  = 1;
            end
        end else if (br) begin
            m_flush = FC;
        end else if (st && !dn) begin
            m_wait = 0;
        end else if (bub) begin
            m_bubble = 1;
            m_l1 = r1;
            m_l2 = r2;
        end
    endtask

    task automatic check_all(input string tag);
        bit stalled;
        stalled = m_bubble || (m_wait >= 0);
        chk({tag, ".pc_we"},    32'(pc_write_en),    32'(!stalled));
        chk({tag, ".ifid_we"},  32'(ifid_write_en),  32'(!stalled));
        chk({tag, ".ifid_fl"},  32'(ifid_flush),     32'(m_flush > 0));
        chk({tag, ".idex_fl"},  32'(idex_flush),     32'((m_flush > 0) || m_bubble));
        chk({tag, ".hold"},     32'(exmem_hold),     32'(m_wait >= 0));
        chk({tag, ".sel1"},     32'(fwd_wb_rs1_sel), 32'(m_s1));
        chk({tag, ".sel2"},     32'(fwd_wb_rs2_sel), 32'(m_s2));
        chk({tag, ".timeout"},  32'(muldiv_timeout), 32'(m_err));
        chk({tag, ".stalls"},   32'(stall_count),    32'(m_stalls));
    endtask

    task automatic cycle(input string tag, input bit br, input bit bub,
                         input bit r1, input bit r2, input bit st,
                         input bit dn);
        branch_taken   = br;
        bubble_enable  = bub;
        fwd_wb_rs1_req = r1;
        fwd_wb_rs2_req = r2;
        muldiv_start   = st;
        muldiv_done    = dn;
        @(posedge clk);
        model_step(br, bub, r1, r2, st, dn);
        #1 check_all(tag);
    endtask

    initial begin
        int base;
        tests  = 0;
        failed = 0;
        model_reset();
        reset = 1'b0;
        {branch_taken, bubble_enable, fwd_wb_rs1_req} = '0;
        {fwd_wb_rs2_req, muldiv_start, muldiv_done} = '0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1 check_all("rst_low");
        reset = 1'b1;
        cycle("rst_rel", 0, 0, 0, 0, 0, 0);

        // 2: bubble with rs2 forward
        cycle("bub_req", 0, 1, 0, 1, 0, 0);
        chk("bub.idex_flush", 32'(idex_flush), 32'd1);
        cycle("bub_after", 0, 0, 0, 0, 0, 0);
        chk("bub.rs2_sel", 32'(fwd_wb_rs2_sel), 32'd1);
        chk("bub.count", 32'(stall_count), 32'd1);
        cycle("bub_clr", 0, 0, 0, 0, 0, 0);

        // 3: branch squashes bubble
        base = m_stalls;
        cycle("br_bub", 1, 1, 1, 1, 0, 0);
        cycle("br_fl2", 0, 1, 0, 0, 0, 0);
        chk("br.ifid_flush", 32'(ifid_flush), 32'd1);
        cycle("br_end", 0, 0, 0, 0, 0, 0);
        chk("br.count", 32'(stall_count), 32'(base));

        // 4: mul/div done after 5 wait cycles
        base = m_stalls;
        cycle("md_start", 0, 0, 0, 0, 1, 0);
        repeat (4) cycle("md_wait", 1, 1, 0, 0, 0, 0);
        cycle("md_done", 0, 0, 0, 0, 0, 1);
        chk("md.count", 32'(stall_count), 32'(base + 5));

        // single-cycle op: no stall
        cycle("md_1cyc", 0, 0, 0, 0, 1, 1);

        // 5: timeout
        cycle("to_start", 0, 0, 0, 0, 1, 0);
        repeat (8) cycle("to_wait", 0, 0, 0, 0, 0, 0);
        chk("to.sticky", 32'(muldiv_timeout), 32'd1);
        repeat (3) cycle("to_keep", 0, 1, 1, 0, 0, 0);

        // 6: async reset mid wait
        cycle("ar_start", 0, 0, 0, 0, 1, 0);
        repeat (3) cycle("ar_wait", 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("ar_async");
        @(negedge clk);
        reset = 1'b1;
        cycle("ar_rel", 0, 0, 0, 0, 0, 0);

        // random traffic, runs long enough to saturate stall_count
        for (int i = 0; i < 400; i++) begin
            cycle("rnd",
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0,
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0);
        end
        chk("sat.count", 32'(stall_count), 32'(m_stalls));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
